// File: rtl/controller_wr.sv
// rtl/controller_wr.sv - async FIFO write-side controller
// Write pointer generation, read-pointer synchronizer and full/almost_full/overflow flags.
module controller_wr #(
  parameter int PTRWIDTH  = 4,
  parameter int AF_THRESH = 14
) (
  input  logic                wclk,
  input  logic                reset_L,
  input  logic                push,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic                wen,
  output logic [PTRWIDTH-1:0] waddr,
  output logic [PTRWIDTH:0]   wrptr_bin,
  output logic [PTRWIDTH:0]   wrptr_gray,
  input  logic [PTRWIDTH:0]   rdptr_gray
);

  localparam int PW = PTRWIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(1) << PTRWIDTH;
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);

  logic [PW-1:0] rd_ff1_q, rd_ff2_q;
  logic [PW-1:0] wrptr_bin_q, wrptr_bin_d;
  logic [PW-1:0] wrptr_gray_q, wrptr_gray_d;
  logic [PW-1:0] rdptr_bin_sync;
  logic [PW-1:0] level;
  logic          overflow_q, overflow_d;
  logic          full_w, almost_full_w, wen_w;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Flags depend only on registered state, so push never reaches full combinationally.
  always_comb begin
    rdptr_bin_sync = gray2bin(rd_ff2_q);
    level          = wrptr_bin_q - rdptr_bin_sync;
    full_w         = (level == DEPTH_C);
    almost_full_w  = (level >= AF_C);
    wen_w          = push && !full_w;
    wrptr_bin_d    = wrptr_bin_q;
    wrptr_gray_d   = wrptr_gray_q;
    if (wen_w) begin
      wrptr_bin_d  = wrptr_bin_q + PW'(1);
      wrptr_gray_d = wrptr_bin_d ^ (wrptr_bin_d >> 1);
    end
    overflow_d     = overflow_q | (push & full_w);
  end

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ff1_q     <= '0;
      rd_ff2_q     <= '0;
      wrptr_bin_q  <= '0;
      wrptr_gray_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ff1_q     <= rdptr_gray;
      rd_ff2_q     <= rd_ff1_q;
      wrptr_bin_q  <= wrptr_bin_d;
      wrptr_gray_q <= wrptr_gray_d;
      overflow_q   <= overflow_d;
    end
  end

  assign full        = full_w;
  assign almost_full = almost_full_w;
  assign overflow    = overflow_q;
  assign wen         = wen_w;
  assign waddr       = wrptr_bin_q[PTRWIDTH-1:0];
  assign wrptr_bin   = wrptr_bin_q;
  assign wrptr_gray  = wrptr_gray_q;

endmodule
